// File: rtl/cam_timing_tx.sv
// Camera-style video timing transmitter: pulls pixels from a valid/ready source and
// emits them with active-low frame/line valid and fixed line and frame blanking.
module cam_timing_tx #(
   parameter int DATA_W   = 16,
   parameter int H_ACTIVE = 640,
   parameter int H_BLANK  = 80,
   parameter int V_ACTIVE = 512,
   parameter int V_BLANK  = 1000,
   parameter int FV_SETUP = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic              b_fval,
   output logic              b_lval,
   output logic [DATA_W-1:0] out_data,
   output logic              frame_done,
   output logic              underrun,
   output logic              underrun_flag
);

   localparam int M_A   = (FV_SETUP > H_BLANK) ? FV_SETUP : H_BLANK;
   localparam int M_B   = (H_ACTIVE > V_BLANK) ? H_ACTIVE : V_BLANK;
   localparam int H_MAX = (M_A > M_B) ? M_A : M_B;
   localparam int HW    = (H_MAX > 1) ? $clog2(H_MAX) : 1;
   localparam int VW    = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

   localparam logic [HW-1:0] SETUP_LAST  = HW'(FV_SETUP - 1);
   localparam logic [HW-1:0] HBLANK_LAST = HW'(H_BLANK - 1);
   localparam logic [HW-1:0] HACT_LAST   = HW'(H_ACTIVE - 1);
   localparam logic [HW-1:0] VBLANK_LAST = HW'(V_BLANK - 1);
   localparam logic [VW-1:0] LINE_LAST   = VW'(V_ACTIVE - 1);

   typedef enum logic [2:0] {
      IDLE,
      FRAME_SETUP,
      LINE_BLANK,
      LINE_ACTIVE,
      FRAME_BLANK
   } state_t;

   state_t          state_reg, state_next;
   logic [HW-1:0]   h_cnt_reg, h_cnt_next;
   logic [VW-1:0]   v_cnt_reg, v_cnt_next;
   logic            frame_start;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         h_cnt_reg <= '0;
         v_cnt_reg <= '0;
      end else begin
         state_reg <= state_next;
         h_cnt_reg <= h_cnt_next;
         v_cnt_reg <= v_cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      v_cnt_next = v_cnt_reg;
      case (state_reg)
         IDLE: begin
            if (enable) state_next = FRAME_SETUP;
         end
         FRAME_SETUP: begin
            if (h_cnt_reg == SETUP_LAST) state_next = LINE_BLANK;
         end
         LINE_BLANK: begin
            if (h_cnt_reg == HBLANK_LAST) state_next = LINE_ACTIVE;
         end
         LINE_ACTIVE: begin
            if (h_cnt_reg == HACT_LAST) begin
               if (v_cnt_reg == LINE_LAST) begin
                  state_next = FRAME_BLANK;
               end else begin
                  v_cnt_next = v_cnt_reg + 1'b1;
                  state_next = LINE_BLANK;
               end
            end
         end
         FRAME_BLANK: begin
            // enable only matters here and in IDLE, so a started frame always completes
            if (h_cnt_reg == VBLANK_LAST) state_next = enable ? FRAME_SETUP : IDLE;
         end
         default: state_next = IDLE;
      endcase

      frame_start = (state_next == FRAME_SETUP) && (state_reg != FRAME_SETUP);
      if (frame_start) v_cnt_next = '0;

      if ((state_next != state_reg) || (state_reg == IDLE)) begin
         h_cnt_next = '0;
      end else begin
         h_cnt_next = h_cnt_reg + 1'b1;
      end
   end

   assign s_ready = (state_reg == LINE_ACTIVE);

   // Pins follow the FSM state by one cycle; a missing pixel is replaced by zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         b_fval        <= 1'b1;
         b_lval        <= 1'b1;
         out_data      <= '0;
         frame_done    <= 1'b0;
         underrun      <= 1'b0;
         underrun_flag <= 1'b0;
      end else begin
         b_fval     <= !((state_reg == FRAME_SETUP) || (state_reg == LINE_BLANK) ||
                         (state_reg == LINE_ACTIVE));
         b_lval     <= (state_reg != LINE_ACTIVE);
         frame_done <= (state_reg == FRAME_BLANK) && (h_cnt_reg == '0);
         underrun   <= (state_reg == LINE_ACTIVE) && !s_valid;
         if ((state_reg == LINE_ACTIVE) && s_valid) begin
            out_data <= s_data;
         end else begin
            out_data <= '0;
         end
         if (frame_start) begin
            underrun_flag <= 1'b0;
         end else if ((state_reg == LINE_ACTIVE) && !s_valid) begin
            underrun_flag <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_cam_timing_tx.sv
// Directed bench for cam_timing_tx with a small frame (4x3 active, 2/5 blanking, 1 setup).
module tb_cam_timing_tx;

   localparam int DATA_W = 16;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              enable;
   logic [DATA_W-1:0] s_data;
   logic              s_valid;
   logic              s_ready;
   logic              b_fval;
   logic              b_lval;
   logic [DATA_W-1:0] out_data;
   logic              frame_done;
   logic              underrun;
   logic              underrun_flag;

   int n_checks = 0;
   int n_errors = 0;

   // k is the output cycle number within a 24-cycle frame; k=0 is the edge entering FRAME_SETUP
   bit idle;
   int k;
   int frame_no;
   int drop_frame;
   int pix;
   int exp_pix;
   bit flag_exp;
   int fv_cnt, lv_cnt, rdy_cnt, fd_cnt;

   cam_timing_tx #(
      .DATA_W  (DATA_W),
      .H_ACTIVE(4),
      .H_BLANK (2),
      .V_ACTIVE(3),
      .V_BLANK (5),
      .FV_SETUP(1)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable       (enable),
      .s_data       (s_data),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .b_fval       (b_fval),
      .b_lval       (b_lval),
      .out_data     (out_data),
      .frame_done   (frame_done),
      .underrun     (underrun),
      .underrun_flag(underrun_flag)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (k=%0d idle=%0b t=%0t)", tag, got, exp, k, idle, $time);
      end
   endtask

   function automatic bit lval_low_at(input int kk);
      return (kk >= 4 && kk <= 7) || (kk >= 10 && kk <= 13) || (kk >= 16 && kk <= 19);
   endfunction

   function automatic bit ready_at(input int kk);
      return (kk >= 3 && kk <= 6) || (kk >= 9 && kk <= 12) || (kk >= 15 && kk <= 18);
   endfunction

   task automatic check_reset_values(input string tag);
      check({tag, "_b_fval"}, b_fval, 1);
      check({tag, "_b_lval"}, b_lval, 1);
      check({tag, "_out_data"}, out_data, 0);
      check({tag, "_s_ready"}, s_ready, 0);
      check({tag, "_frame_done"}, frame_done, 0);
      check({tag, "_underrun"}, underrun, 0);
      check({tag, "_underrun_flag"}, underrun_flag, 0);
   endtask

   task automatic check_outputs();
      bit act, lv_low, drop_now;
      logic [31:0] d_exp;
      act      = !idle;
      lv_low   = act && lval_low_at(k);
      drop_now = lv_low && (frame_no == drop_frame) && (k == 12);
      if (act && k == 0) begin
         flag_exp = 1'b0;
         fv_cnt = 0; lv_cnt = 0; rdy_cnt = 0; fd_cnt = 0;
      end
      d_exp = 0;
      if (lv_low && !drop_now) begin
         d_exp = exp_pix;
         exp_pix++;
      end
      if (drop_now) flag_exp = 1'b1;

      check("b_fval", b_fval, !(act && k >= 1 && k <= 19));
      check("b_lval", b_lval, !lv_low);
      check("s_ready", s_ready, act && ready_at(k));
      check("out_data", out_data, d_exp);
      check("frame_done", frame_done, act && k == 20);
      check("underrun", underrun, drop_now);
      check("underrun_flag", underrun_flag, flag_exp);

      if (!b_fval) fv_cnt++;
      if (!b_lval) lv_cnt++;
      if (s_ready) rdy_cnt++;
      if (frame_done) fd_cnt++;
      if (act && k == 20) begin
         check("fval_low_len", fv_cnt, 19);
         check("lval_low_total", lv_cnt, 12);
         check("ready_total", rdy_cnt, 12);
         check("frame_done_count", fd_cnt, 1);
      end
   endtask

   // One clock: predict the frame position, wait for the outputs, check, drive next inputs.
   task automatic tick();
      bit consume;
      consume = s_ready && s_valid;
      if (idle) begin
         if (enable) begin idle = 1'b0; k = 0; frame_no++; end
      end else if (k == 23) begin
         if (enable) begin k = 0; frame_no++; end
         else idle = 1'b1;
      end else begin
         k++;
      end
      @(negedge clk);
      if (consume) pix++;
      check_outputs();
      s_valid = !(!idle && frame_no == drop_frame && k == 11);
      s_data  = DATA_W'(pix);
   endtask

   initial begin
      rst_n = 1'b0; enable = 1'b0; s_valid = 1'b0; s_data = '0;
      idle = 1'b1; k = 0; frame_no = 0; drop_frame = -1;
      pix = 1; exp_pix = 1; flag_exp = 1'b0;
      fv_cnt = 0; lv_cnt = 0; rdy_cnt = 0; fd_cnt = 0;
      repeat (3) @(negedge clk);
      check_reset_values("reset");
      rst_n = 1'b1;
      s_valid = 1'b1;
      s_data = DATA_W'(pix);

      // idle with s_valid held high: nothing consumed, pins quiet
      repeat (50) tick();

      // single frame from a one-cycle enable pulse, pixels 1..12
      enable = 1'b1; tick(); enable = 1'b0;
      repeat (30) tick();

      // back-to-back frames; second one drops the 3rd pixel of line 2;
      // enable falls during line 1 of the third, which must still complete
      drop_frame = frame_no + 2;
      enable = 1'b1;
      repeat (53) tick();
      enable = 1'b0;
      repeat (30) tick();
      drop_frame = -1;

      // asynchronous reset during line 2, then a clean frame
      enable = 1'b1; tick(); enable = 1'b0;
      repeat (11) tick();
      rst_n = 1'b0;
      #1;
      check_reset_values("async_reset");
      idle = 1'b1; k = 0; flag_exp = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_values("held_reset");
      rst_n = 1'b1;
      exp_pix = pix;
      s_data = DATA_W'(pix);
      enable = 1'b1; tick(); enable = 1'b0;
      repeat (30) tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
